week6_ex1_exhaustive_checker: RTL
=================================

# week6_ex1_exhaustive_checker

Sequential hardware checker for the 3-input, 1-output combinational exercise circuits, with golden function Y = (A' AND B') OR (B AND C). It drives all 8 input combinations in ascending order, waits a programmable settle time, samples Y and compares it with a golden truth table. It accumulates pass/fail counts and a per-vector failure mask. It sits opposite the DUT: its a/b/c outputs drive the DUT inputs, and the DUT output returns on y.

## Interface
- SETTLE, 2: cycles each vector is driven before sampling; legal range 1..15.
- EXPECT, 8'h8B: golden truth table. Bit i is the expected y for {a,b,c} = i (a is the MSB). The default encodes (A'B') | (BC).
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run a full sweep.
- a  output  1  DUT input A (bit 2 of the vector index).
- b  output  1  DUT input B (bit 1).
- c  output  1  DUT input C (bit 0).
- y  input  1  DUT output under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or rst.
- pass_count  output  4  number of vectors that matched (0..8).
- fail_count  output  4  number of vectors that mismatched (0..8).
- fail_mask  output  8  bit i is set if vector i mismatched.
- all_pass  output  1  equals done AND (fail_count == 0).

## Operation
- FSM states:
  - IDLE
  - DRIVE: apply the vector, run the settle counter
  - SAMPLE: compare y against the golden bit
  - DONE
- IDLE / DONE:
  - a, b, c = 0; busy = 0.
  - start = 1 is accepted. On acceptance: clear vector index, settle counter, pass_count, fail_count and fail_mask; clear done; go to DRIVE.
- DRIVE:
  - {a,b,c} = index; busy = 1.
  - The settle counter increments each cycle.
  - When the counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE:
  - {a,b,c} is held.
  - y is compared with EXPECT[index]. A match increments pass_count. A mismatch increments fail_count and sets fail_mask[index].
  - Any non-0/1 value on y counts as a mismatch.
  - If index == 7, go to DONE and set done; otherwise increment index, clear the settle counter and go to DRIVE.
- start is ignored while busy (DRIVE or SAMPLE).
- The result registers hold their values in DONE until a new start is accepted or rst is asserted.
- Arithmetic and widths:
  - The index is 3 bits and never wraps within a sweep; the sweep terminates at 7.
  - Each count is 4 bits and saturates naturally at 8.
  - pass_count + fail_count == 8 whenever done = 1.

## Timing
- Reset values (all outputs): a = b = c = 0, busy = 0, done = 0, pass_count = 0, fail_count = 0, fail_mask = 0, all_pass = 0; state IDLE.
- rst has priority over everything, including start in the same cycle and reset mid-sweep. A sweep interrupted by reset is abandoned with no partial results retained.
- Numbering: edge 0 is the edge on which start is sampled.
  - Edge 1: the FSM enters DRIVE; {a,b,c} = 000 is visible; busy = 1.
  - Vector i is presented from edge i·(SETTLE+1)+1.
  - Vector i's compare result is registered at edge (i+1)·(SETTLE+1)+1.
- done rises at edge 8·(SETTLE+1)+1, and busy falls at the same edge. With SETTLE=2 this is edge 25.
- The DUT must settle within SETTLE+1 cycles of a vector change; y is sampled at the end of the SAMPLE cycle.
- start asserted on the same edge done rises is not seen, because the FSM is still busy when that start is sampled. start on any later DONE cycle restarts the sweep.

## Test plan
- Golden model of (A'B')|(BC) on y, SETTLE=2, start at edge 0 -> done = 1 and busy = 0 at edge 25; pass_count = 8, fail_count = 0, fail_mask = 8'h00, all_pass = 1; vectors observed at a/b/c in order 000..111.
- y tied to 0 -> pass_count = 4, fail_count = 4, fail_mask = 8'h8B, all_pass = 0.
- y = inverted golden -> pass_count = 0, fail_count = 8, fail_mask = 8'hFF.
- rst at edge 10 mid-sweep -> next cycle all outputs equal their reset values; a new start then completes with the golden result at 25 edges after it is sampled.
- start pulsed at edge 5 (while busy) -> ignored, and done still rises at edge 25. A second start while in DONE -> counts and mask clear on acceptance and the sweep reruns.
- SETTLE=1, golden y -> done at edge 17; each vector is held exactly 2 cycles.

Source files
------------

// File: rtl/week6_ex1_exhaustive_checker.sv
// Exhaustive sweep checker for a 3-input, 1-output combinational circuit.
// Drives {a,b,c} = 0..7, waits SETTLE cycles per vector, then compares y to EXPECT.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                one-cycle request to run a sweep (ignored while busy)
//   a, b, c              stimulus to the circuit under test (a is the index MSB)
//   y                    response from the circuit under test
//   busy, done           sweep in progress / sweep complete, results valid
//   pass_count           vectors that matched
//   fail_count           vectors that mismatched
//   fail_mask            bit i set when vector i mismatched
//   all_pass             done with zero mismatches
module week6_ex1_exhaustive_checker #(
    parameter int unsigned SETTLE = 2,
    parameter logic [7:0]  EXPECT = 8'h8B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_count,
    output logic [3:0] fail_count,
    output logic [7:0] fail_mask,
    output logic       all_pass
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       req;
    logic       active;
    logic       accept;

    assign active = (state == DRIVE) || (state == SAMPLE);
    assign accept = ((state == IDLE) || (state == FINISH)) && req;

    // The start request is captured one edge before acceptance, and only
    // while no sweep is running, so a start sampled while busy is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, FINISH: begin
                if (req) state_nx = DRIVE;
            end
            DRIVE: begin
                if (cnt == LAST) state_nx = SAMPLE;
            end
            SAMPLE: begin
                if (idx == 3'd7) state_nx = FINISH;
                else             state_nx = DRIVE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req        <= 1'b0;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            done       <= 1'b0;
            pass_count <= 4'd0;
            fail_count <= 4'd0;
            fail_mask  <= 8'h00;
        end else begin
            req <= start && !active;
            if (accept) begin
                idx        <= 3'd0;
                cnt        <= 4'd0;
                done       <= 1'b0;
                pass_count <= 4'd0;
                fail_count <= 4'd0;
                fail_mask  <= 8'h00;
            end else if (state == DRIVE) begin
                cnt <= cnt + 4'd1;
            end else if (state == SAMPLE) begin
                // Case equality so an X or Z on y is scored as a mismatch.
                if (y === EXPECT[idx]) begin
                    pass_count <= pass_count + 4'd1;
                end else begin
                    fail_count     <= fail_count + 4'd1;
                    fail_mask[idx] <= 1'b1;
                end
                cnt <= 4'd0;
                if (idx == 3'd7) done <= 1'b1;
                else             idx  <= idx + 3'd1;
            end
        end
    end

    assign busy        = active;
    assign {a, b, c}   = active ? idx : 3'b000;
    assign all_pass    = done && (fail_count == 4'd0);

endmodule
